fft_frontend: RTL and testbench

FFT_FRONTEND -- requirements
Module: fft_frontend

---
 rtl/fft_frontend_pkg.sv | 23 ++
 rtl/fft_frontend_sat.sv | 37 +++
 rtl/fft_frontend.sv | 187 ++++++++++++++++++
 tb/tb_fft_frontend.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_frontend_pkg.sv
// Shared definitions for the FFT input front end: default geometry, the
// channel-tag width and the framing FSM encoding.
package fft_frontend_pkg;

   localparam int DEF_WIDTH     = 16;  // signed sample width
   localparam int DEF_NALL      = 9;   // log2 of FFT points per frame
   localparam int DEF_CH        = 2;   // interleaved input channels
   localparam int DEF_GAP_MAX   = 64;  // idle cycles that abort a frame
   localparam int DEF_SYNC_MODE = 1;   // 1 = framing aligned to din_sof
   localparam int CHW           = 2;   // channel tag width, fixed
   localparam int SHIFT_W       = 3;   // gain shift 0..7

   typedef enum logic {
      ST_IDLE = 1'b0,   // waiting for a start-of-frame marker
      ST_RUN  = 1'b1    // accepting samples
   } fe_state_e;

   // Width of a counter that must be able to hold the value gap_max.
   function automatic int gap_width(input int gap_max);
      return (gap_max < 2) ? 1 : $clog2(gap_max + 1);
   endfunction

endpackage

// File: rtl/fft_frontend_sat.sv
// Combinational gain stage: left-shift a signed sample by 0..7 bits in a
// WIDTH+7 bit intermediate and clip the result back into WIDTH bits.
module fe_sat_shift
   import fft_frontend_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic signed [WIDTH-1:0]   din_i,
   input  logic        [SHIFT_W-1:0] shift_i,
   output logic signed [WIDTH-1:0]   dout_o,
   output logic                      sat_o
);

   localparam int XW = WIDTH + 7;

   logic signed [XW-1:0] wide;
   logic        [XW-WIDTH:0] top_bits;

   // Shift at full precision, then clip to the signed WIDTH-bit range.
   // NOTE: every output of a combinational block is assigned on every path
   // (here and in the top's next-state logic), otherwise a latch is inferred.
   always_comb begin
      wide     = XW'(din_i) <<< shift_i;
      // The value fits iff the sign bit of the narrow result agrees with
      // every bit above it.
      top_bits = wide[XW-1:WIDTH-1];
      sat_o    = !((&top_bits) || !(|top_bits));
      if (!sat_o) begin
         dout_o = wide[WIDTH-1:0];
      end else if (wide[XW-1]) begin
         dout_o = {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
         dout_o = {1'b0, {(WIDTH-1){1'b1}}};
      end
   end

endmodule

// File: rtl/fft_frontend.sv
// FFT input front end: accepts interleaved multi-channel ADC samples, scales
// them with saturation, tags each with a per-channel frame index and flags
// frame completion and frame aborts. One cycle latency, registered outputs.
module fft_frontend
   import fft_frontend_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int NALL      = DEF_NALL,
   parameter int CH        = DEF_CH,
   parameter int SYNC_MODE = DEF_SYNC_MODE,
   parameter int GAP_MAX   = DEF_GAP_MAX
) (
   input  logic                    clk,
   input  logic                    areset,
   input  logic                    din_en,
   input  logic                    din_sof,
   input  logic [CHW-1:0]          din_ch,
   input  logic signed [WIDTH-1:0] din,
   input  logic [SHIFT_W-1:0]      cfg_shift,
   output logic                    dout_en,
   output logic [CHW-1:0]          dout_ch,
   output logic [NALL-1:0]         dout_cnt,
   output logic signed [WIDTH-1:0] dout,
   output logic                    dout_sat,
   output logic                    frame_done,
   output logic                    frame_err
);

   localparam int              GW          = gap_width(GAP_MAX);
   localparam logic [GW-1:0]   GAP_LAST    = GW'(GAP_MAX - 1);
   localparam int              CHL         = CHW + 1;
   localparam logic [CHL-1:0]  CH_LIM      = CHL'(CH);
   localparam logic [NALL-1:0] CNT_IDLE    = '1;
   localparam fe_state_e       RESET_STATE = (SYNC_MODE == 0) ? ST_RUN : ST_IDLE;

   // Framing state
   fe_state_e       state_q, state_d;
   logic [GW-1:0]   gap_q, gap_d;
   logic [NALL-1:0] cnt_q [CH];
   logic [NALL-1:0] cnt_d [CH];

   // Per-cycle decisions
   logic            ch_ok;
   logic            accept;
   logic            timeout;
   logic            restart;
   logic            partial;
   logic            err_d;
   logic [NALL-1:0] sel_cnt;

   // Scaled sample
   logic signed [WIDTH-1:0] scaled;
   logic                    scaled_sat;

   // Output registers
   logic                    dout_en_q;
   logic [CHW-1:0]          dout_ch_q;
   logic [NALL-1:0]         dout_cnt_q;
   logic signed [WIDTH-1:0] dout_q;
   logic                    dout_sat_q;
   logic                    frame_done_q;
   logic                    frame_err_q;

   fe_sat_shift #(
      .WIDTH (WIDTH)
   ) u_sat_shift (
      .din_i   (din),
      .shift_i (cfg_shift),
      .dout_o  (scaled),
      .sat_o   (scaled_sat)
   );

   // Framing FSM next state: sample acceptance and idle-gap timeout.
   always_comb begin
      ch_ok   = ({1'b0, din_ch} < CH_LIM);
      accept  = 1'b0;
      timeout = 1'b0;
      state_d = state_q;
      gap_d   = gap_q;
      case (state_q)
         ST_IDLE: begin
            // Only a start-of-frame on a real channel opens a frame; anything
            // else is discarded without comment.
            if (din_en && din_sof && ch_ok) begin
               accept  = 1'b1;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (din_en) begin
               accept = ch_ok;
               gap_d  = '0;
            end else if (gap_q == GAP_LAST) begin
               timeout = 1'b1;
               gap_d   = '0;
               if (SYNC_MODE != 0) begin
                  state_d = ST_IDLE;
               end
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end
         default: state_d = RESET_STATE;
      endcase
   end

   // Per-channel frame counters, the index reported for this sample and the
   // frame-abort condition.
   always_comb begin
      partial = 1'b0;
      for (int c = 0; c < CH; c++) begin
         if (cnt_q[c] != CNT_IDLE) begin
            partial = 1'b1;
         end
      end
      // A start-of-frame or a timeout realigns every channel to the frame
      // boundary; the sof channel then immediately takes index 0.
      restart = timeout || (accept && din_sof);
      sel_cnt = CNT_IDLE;
      for (int c = 0; c < CH; c++) begin
         cnt_d[c] = restart ? CNT_IDLE : cnt_q[c];
         if (accept && (CHW'(c) == din_ch)) begin
            cnt_d[c] = din_sof ? '0 : cnt_q[c] + NALL'(1);
         end
         if (CHW'(c) == din_ch) begin
            sel_cnt = cnt_d[c];
         end
      end
      // Invalid channel tags always count as an error; a realignment is only
      // an abort if some channel was part-way through a frame.
      err_d = (din_en && !ch_ok) || (restart && partial);
   end

   // Framing state registers.
   // NOTE: clocked state uses non-blocking assignments so every register
   // samples its pre-edge inputs regardless of statement order.
   // NOTE: the channel counters are a few flops rather than a RAM, so they
   // take the asynchronous reset like the rest of the state.
   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         state_q <= RESET_STATE;
         gap_q   <= '0;
         for (int c = 0; c < CH; c++) begin
            cnt_q[c] <= CNT_IDLE;
         end
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
         for (int c = 0; c < CH; c++) begin
            cnt_q[c] <= cnt_d[c];
         end
      end
   end

   // Output registers: data fields update only on an accepted sample and hold
   // otherwise; the strobes are single-cycle.
   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         dout_en_q    <= 1'b0;
         dout_ch_q    <= '0;
         dout_cnt_q   <= CNT_IDLE;
         dout_q       <= '0;
         dout_sat_q   <= 1'b0;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         dout_en_q    <= accept;
         frame_done_q <= accept && (sel_cnt == CNT_IDLE);
         frame_err_q  <= err_d;
         if (accept) begin
            dout_ch_q  <= din_ch;
            dout_cnt_q <= sel_cnt;
            dout_q     <= scaled;
            dout_sat_q <= scaled_sat;
         end
      end
   end

   assign dout_en    = dout_en_q;
   assign dout_ch    = dout_ch_q;
   assign dout_cnt   = dout_cnt_q;
   assign dout       = dout_q;
   assign dout_sat   = dout_sat_q;
   assign frame_done = frame_done_q;
   assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_fft_frontend.sv
// Bench for fft_frontend: one free-running (SYNC_MODE=0) and one sof-aligned
// (SYNC_MODE=1) instance share the same stimulus. A behavioural model of the
// framing rules predicts every output of both on every cycle; directed
// sequences add hand-computed expectations.
module tb_fft_frontend;

   localparam int WIDTH   = 16;
   localparam int NALL    = 9;
   localparam int CH      = 2;
   localparam int GAP_MAX = 64;
   localparam int FRAME   = 1 << NALL;
   localparam longint MAXV = (longint'(1) << (WIDTH - 1)) - 1;
   localparam longint MINV = -(longint'(1) << (WIDTH - 1));

   logic                    clk = 1'b0;
   logic                    areset = 1'b0;
   logic                    din_en = 1'b0;
   logic                    din_sof = 1'b0;
   logic [1:0]              din_ch = '0;
   logic signed [WIDTH-1:0] din = '0;
   logic [2:0]              cfg_shift = '0;

   logic             o_en   [2];
   logic [1:0]       o_ch   [2];
   logic [NALL-1:0]  o_cnt  [2];
   logic [WIDTH-1:0] o_dout [2];
   logic             o_sat  [2];
   logic             o_done [2];
   logic             o_err  [2];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fft_frontend #(
      .WIDTH(WIDTH), .NALL(NALL), .CH(CH), .SYNC_MODE(0), .GAP_MAX(GAP_MAX)
   ) dut0 (
      .clk(clk), .areset(areset), .din_en(din_en), .din_sof(din_sof),
      .din_ch(din_ch), .din(din), .cfg_shift(cfg_shift),
      .dout_en(o_en[0]), .dout_ch(o_ch[0]), .dout_cnt(o_cnt[0]), .dout(o_dout[0]),
      .dout_sat(o_sat[0]), .frame_done(o_done[0]), .frame_err(o_err[0])
   );

   fft_frontend #(
      .WIDTH(WIDTH), .NALL(NALL), .CH(CH), .SYNC_MODE(1), .GAP_MAX(GAP_MAX)
   ) dut1 (
      .clk(clk), .areset(areset), .din_en(din_en), .din_sof(din_sof),
      .din_ch(din_ch), .din(din), .cfg_shift(cfg_shift),
      .dout_en(o_en[1]), .dout_ch(o_ch[1]), .dout_cnt(o_cnt[1]), .dout(o_dout[1]),
      .dout_sat(o_sat[1]), .frame_done(o_done[1]), .frame_err(o_err[1])
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model (index 0 = SYNC_MODE 0, 1 = SYNC_MODE 1)
   bit               m_run [2];
   int               m_cnt [2][4];   // last index issued per channel; FRAME-1 = at boundary
   int               m_gap [2];
   bit               e_en   [2];
   int               e_ch   [2];
   int               e_cnt  [2];
   logic [WIDTH-1:0] e_dout [2];
   bit               e_sat  [2];
   bit               e_done [2];
   bit               e_err  [2];

   function automatic void model_reset();
      for (int m = 0; m < 2; m++) begin
         m_run[m] = (m == 0);
         m_gap[m] = 0;
         for (int c = 0; c < 4; c++) m_cnt[m][c] = FRAME - 1;
         e_en[m] = 0; e_ch[m] = 0; e_cnt[m] = FRAME - 1; e_dout[m] = '0;
         e_sat[m] = 0; e_done[m] = 0; e_err[m] = 0;
      end
   endfunction

   function automatic void model_step(input int m);
      bit     valid, acc, partial;
      longint v;
      valid   = din_en && (din_ch < CH);
      partial = 0;
      for (int c = 0; c < CH; c++) if (m_cnt[m][c] != FRAME - 1) partial = 1;
      e_en[m]   = 0;
      e_done[m] = 0;
      e_err[m]  = din_en && !valid;
      if (m_run[m] && !din_en) begin
         m_gap[m]++;
         if (m_gap[m] == GAP_MAX) begin
            m_gap[m] = 0;
            e_err[m] = partial;
            for (int c = 0; c < CH; c++) m_cnt[m][c] = FRAME - 1;
            if (m == 1) m_run[m] = 0;
         end
      end else if (din_en) begin
         m_gap[m] = 0;
      end
      acc = valid && (m_run[m] || din_sof);
      if (acc) begin
         if (din_sof) begin
            if (partial) e_err[m] = 1;
            for (int c = 0; c < CH; c++) m_cnt[m][c] = FRAME - 1;
            m_run[m] = 1;
         end
         m_cnt[m][din_ch] = (m_cnt[m][din_ch] + 1) % FRAME;
         v = longint'(din) * (longint'(1) << cfg_shift);
         e_sat[m] = (v > MAXV) || (v < MINV);
         if (v > MAXV) v = MAXV;
         if (v < MINV) v = MINV;
         e_dout[m] = WIDTH'(v);
         e_en[m]   = 1;
         e_ch[m]   = int'(din_ch);
         e_cnt[m]  = m_cnt[m][din_ch];
         e_done[m] = (e_cnt[m] == FRAME - 1);
      end
   endfunction

   always @(posedge clk or negedge areset) begin
      if (!areset) model_reset();
      else begin
         model_step(0);
         model_step(1);
      end
   end

   // Compare every output of both instances half a cycle after each edge.
   always @(negedge clk) begin
      for (int m = 0; m < 2; m++) begin
         check($sformatf("dut%0d dout_en", m),    o_en[m],   e_en[m]);
         check($sformatf("dut%0d dout_ch", m),    o_ch[m],   e_ch[m]);
         check($sformatf("dut%0d dout_cnt", m),   o_cnt[m],  e_cnt[m]);
         check($sformatf("dut%0d dout", m),       o_dout[m], e_dout[m]);
         check($sformatf("dut%0d dout_sat", m),   o_sat[m],  e_sat[m]);
         check($sformatf("dut%0d frame_done", m), o_done[m], e_done[m]);
         check($sformatf("dut%0d frame_err", m),  o_err[m],  e_err[m]);
      end
   end

   // ---------------- stimulus
   // Drive one cycle's inputs just after a falling edge; return at the next
   // falling edge, when the outputs for those inputs are visible.
   task automatic send(input bit en, input bit sof, input int ch, input int d, input int sh);
      din_en    = en;
      din_sof   = sof;
      din_ch    = 2'(ch);
      din       = WIDTH'(d);
      cfg_shift = 3'(sh);
      @(negedge clk);
   endtask

   task automatic check_reset_values(input string tag);
      for (int m = 0; m < 2; m++) begin
         check($sformatf("%s dut%0d dout_en", tag, m),    o_en[m],   1'b0);
         check($sformatf("%s dut%0d dout_cnt", tag, m),   o_cnt[m],  9'h1FF);
         check($sformatf("%s dut%0d dout", tag, m),       o_dout[m], 16'h0000);
         check($sformatf("%s dut%0d dout_ch", tag, m),    o_ch[m],   2'd0);
         check($sformatf("%s dut%0d dout_sat", tag, m),   o_sat[m],  1'b0);
         check($sformatf("%s dut%0d frame_done", tag, m), o_done[m], 1'b0);
         check($sformatf("%s dut%0d frame_err", tag, m),  o_err[m],  1'b0);
      end
   endtask

   initial begin
      int n_done;
      int done_idx [2];
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      #2 areset = 1'b1;

      // sof-aligned instance ignores samples until a start-of-frame
      for (int i = 0; i < 10; i++) begin
         send(1, 0, 0, i + 1, 0);
         check("nosof dut1 dout_en", o_en[1], 1'b0);
      end
      check("nosof dut0 dout_cnt", o_cnt[0], 9'd9);

      // full frame: sof on ch0 then alternating ch0/ch1, 1024 samples total
      n_done = 0;
      done_idx[0] = -1;
      done_idx[1] = -1;
      for (int i = 0; i < 1024; i++) begin
         send(1, (i == 0), i % 2, i, 0);
         if (i == 0) begin
            check("sof dut1 dout_en", o_en[1], 1'b1);
            check("sof dut1 dout_cnt", o_cnt[1], 9'd0);
            check("sof dut0 frame_err", o_err[0], 1'b1);
         end
         if (o_done[1] === 1'b1) begin
            if (n_done < 2) done_idx[n_done] = i;
            n_done++;
            check("frame_done dut1 dout_cnt", o_cnt[1], 9'd511);
         end
      end
      check("frame_done count", n_done, 2);
      check("frame_done ch0 position", done_idx[0], 1022);
      check("frame_done ch1 position", done_idx[1], 1023);

      // gain and saturation
      send(1, 0, 0, 'h1000, 3);
      check("scale 0x1000<<3", o_dout[1], 16'h7FFF);
      check("scale 0x1000<<3 sat", o_sat[1], 1'b1);
      // -4096*8 lands exactly on the most negative code: representable, no clip
      send(1, 0, 0, -4096, 3);
      check("scale 0xF000<<3", o_dout[1], 16'h8000);
      check("scale 0xF000<<3 sat", o_sat[1], 1'b0);
      send(1, 0, 0, -4096, 4);
      check("scale 0xF000<<4", o_dout[1], 16'h8000);
      check("scale 0xF000<<4 sat", o_sat[1], 1'b1);
      send(1, 0, 0, 'h0010, 2);
      check("scale 0x0010<<2", o_dout[1], 16'h0040);
      check("scale 0x0010<<2 sat", o_sat[1], 1'b0);

      // 100 samples into a frame, then a 64-cycle gap aborts it
      for (int i = 0; i < 96; i++) send(1, 0, 0, i, 0);
      check("gap pre dut1 dout_cnt", o_cnt[1], 9'd99);
      for (int g = 1; g <= GAP_MAX; g++) begin
         send(0, 0, 0, 0, 0);
         check($sformatf("gap%0d dut0 frame_err", g), o_err[0], (g == GAP_MAX));
         check($sformatf("gap%0d dut1 frame_err", g), o_err[1], (g == GAP_MAX));
      end
      send(1, 0, 0, 7, 0);
      check("post-gap dut0 dout_en", o_en[0], 1'b1);
      check("post-gap dut0 dout_cnt", o_cnt[0], 9'd0);
      check("post-gap dut1 dout_en", o_en[1], 1'b0);

      // sof in the middle of a frame aborts it, then an invalid channel tag
      send(1, 1, 0, 1, 0);
      for (int i = 0; i < 200; i++) send(1, 0, 0, i, 1);
      check("mid dut1 dout_cnt", o_cnt[1], 9'd200);
      send(1, 1, 0, 2, 0);
      check("resof dut1 frame_err", o_err[1], 1'b1);
      check("resof dut1 dout_cnt", o_cnt[1], 9'd0);
      send(1, 0, 3, 5, 0);
      check("badch dut1 dout_en", o_en[1], 1'b0);
      check("badch dut1 frame_err", o_err[1], 1'b1);

      // randomized traffic, including occasional long gaps and bad tags
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            repeat ($urandom_range(55, 70)) send(0, 0, 0, 0, 0);
         end
         send($urandom_range(0, 9) < 7,
              $urandom_range(0, 599) == 0,
              ($urandom_range(0, 19) == 0) ? int'($urandom_range(2, 3))
                                           : int'($urandom_range(0, 1)),
              int'($urandom),
              int'($urandom_range(0, 7)));
      end

      // reset in the middle of a frame
      send(1, 1, 1, 3, 0);
      for (int i = 0; i < 50; i++) send(1, 0, i % 2, i, 2);
      #2 areset = 1'b0;
      #1 check_reset_values("async reset");
      @(negedge clk);
      check_reset_values("held reset");
      #2 areset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         send(1, 0, i % 2, i, 0);
         check("post-reset nosof dut1 dout_en", o_en[1], 1'b0);
      end
      send(1, 1, 0, 9, 0);
      check("post-reset sof dut1 dout_en", o_en[1], 1'b1);
      check("post-reset sof dut1 dout_cnt", o_cnt[1], 9'd0);
      check("post-reset sof dut1 frame_err", o_err[1], 1'b0);
      send(0, 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
